// File: rtl/tanh_activation_arbiter.sv
// ============================================================================
// Module  : tanh_activation_arbiter
// Brief   : Round-robin arbiter sharing one combinational tanh unit among
//           NUM_REQ requesters (IDLE -> EVAL -> HOLD per transaction).
//           Optional busy-cycle counter: define TANH_ARB_BUSY_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tanh_activation_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_z,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           act_z,
  input  logic [7:0]           act_a,
  output logic                 resp_valid,
  output logic [7:0]           resp_a,
  output logic [ID_W-1:0]      resp_id,
  input  logic                 resp_ready
`ifdef TANH_ARB_BUSY_COUNT_EN
  ,
  output logic [15:0]          busy_cycles
`endif
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EVAL = 2'd1;
  localparam logic [1:0] c_HOLD = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [7:0]      z_q, z_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      resp_a_q, resp_a_d;
  logic            resp_valid_q, resp_valid_d;

  logic            w_found;
  logic [ID_W-1:0] w_grant_idx;
  logic [ID_W-1:0] w_cand;
  logic            w_grant;
  logic [7:0]      w_z_arr [NUM_REQ];

  // (base + off) mod NUM_REQ, valid for base, off < NUM_REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_z_arr[gi] = req_z[8*gi +: 8];
    end
  endgenerate

  // Walk from the farthest offset back to rr_q so the nearest valid wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = wrap_add(rr_q, unsigned'(k));
      if (req_valid[w_cand]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= c_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_grant) state_d = c_EVAL;
      c_EVAL:  state_d = c_HOLD;
      c_HOLD:  if (resp_ready) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // Grant strobe is suppressed while rst is high so no pulse escapes a reset cycle.
  always_comb begin
    w_grant   = 1'b0;
    req_ready = '0;
    if (state_q == c_IDLE && w_found && !rst) begin
      w_grant                = 1'b1;
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_d         = rr_q;
    z_d          = z_q;
    id_d         = id_q;
    resp_a_d     = resp_a_q;
    resp_valid_d = resp_valid_q;
    if (w_grant) begin
      rr_d = wrap_add(w_grant_idx, 1);
      z_d  = w_z_arr[w_grant_idx];
      id_d = w_grant_idx;
    end
    if (state_q == c_EVAL) begin
      resp_a_d     = act_a;
      resp_valid_d = 1'b1;
    end
    if (state_q == c_HOLD && resp_ready) resp_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= '0;
      z_q          <= '0;
      id_q         <= '0;
      resp_a_q     <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      z_q          <= z_d;
      id_q         <= id_d;
      resp_a_q     <= resp_a_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign act_z      = z_q;
  assign resp_a     = resp_a_q;
  assign resp_id    = id_q;
  assign resp_valid = resp_valid_q;

`ifdef TANH_ARB_BUSY_COUNT_EN
  logic [15:0] busy_q;

  always_ff @(posedge clk) begin
    if (rst)                                        busy_q <= '0;
    else if (state_q != c_IDLE && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
  end

  assign busy_cycles = busy_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tanh_activation_arbiter.sv
// ============================================================================
// Module  : tb_tanh_activation_arbiter
// Brief   : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tanh_activation_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_z;
  logic [N-1:0]   req_ready;
  logic [7:0]     act_z;
  logic [7:0]     act_a;
  logic           resp_valid;
  logic [7:0]     resp_a;
  logic [1:0]     resp_id;
  logic           resp_ready;
`ifdef TANH_ARB_BUSY_COUNT_EN
  logic [15:0]    busy_cycles;
`endif

  always #5 clk = ~clk;

  tanh_activation_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_z      (req_z),
    .req_ready  (req_ready),
    .act_z      (act_z),
    .act_a      (act_a),
    .resp_valid (resp_valid),
    .resp_a     (resp_a),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
`ifdef TANH_ARB_BUSY_COUNT_EN
    ,
    .busy_cycles(busy_cycles)
`endif
  );

  // Stand-in for the shared tanh unit.
  function automatic logic [7:0] tanh_fn(input logic [7:0] z);
    return (z == 8'h30) ? 8'h2E : (z ^ 8'h5A);
  endfunction

  assign act_a = tanh_fn(act_z);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [7:0]   z;
    int           id;
    logic [7:0]   a;
  } vec_t;

  vec_t tbl [8];

  // One complete transaction starting in IDLE; grant expected immediately.
  task automatic run_txn(input vec_t v);
    req_valid = v.vld; req_z = {N{v.z}}; resp_ready = 1'b0;
    @(negedge clk);
    chk("txn_grant", 32'(req_ready), 32'(1) << v.id);
    tick; req_valid = '0;
    @(negedge clk);
    chk("txn_eval_actz", 32'(act_z), 32'(v.z));
    chk("txn_eval_rv", 32'(resp_valid), 0);
    tick;
    @(negedge clk);
    chk("txn_rv", 32'(resp_valid), 1);
    chk("txn_resp_a", 32'(resp_a), 32'(v.a));
    chk("txn_resp_id", 32'(resp_id), 32'(v.id));
    resp_ready = 1'b1;
    tick; resp_ready = 1'b0;
  endtask

  // Transaction-level reference state
  int         m_ptr, m_id, g;
  bit         m_inflight, m_eval, m_rv;
  logic [7:0] m_z, m_a;

  initial begin
    int ng;
    int gid [5];
    int gcyc [5];
    rst = 1'b1; req_valid = '0; req_z = '0; resp_ready = 1'b0;
    tick;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_act_z", 32'(act_z), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_a", 32'(resp_a), 0);
    tick; rst = 1'b0;

    tbl[0] = '{4'b0100, 8'h30, 2, 8'h2E};
    tbl[1] = '{4'b1111, 8'h11, 3, 8'h4B};
    tbl[2] = '{4'b1111, 8'hC3, 0, 8'h99};
    tbl[3] = '{4'b0001, 8'h80, 0, 8'hDA};
    tbl[4] = '{4'b1000, 8'h7F, 3, 8'h25};
    tbl[5] = '{4'b0110, 8'h01, 1, 8'h5B};
    tbl[6] = '{4'b0110, 8'hFF, 2, 8'hA5};
    tbl[7] = '{4'b0011, 8'h5A, 0, 8'h00};
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // All requesters valid, consumer always ready
    do_reset;
    req_valid = 4'hF; req_z = 32'h44332211; resp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) gid[ng] = i;
        gcyc[ng] = c;
        ng++;
      end
      tick;
    end
    chk("rr_grant_count", 32'(ng), 5);
    if (ng == 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(gid[i]), 32'(i % N));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 3);
    end

    // Backpressure
    do_reset;
    req_valid = 4'b0010; req_z = 32'h00006C00; resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 32'b0010);
    tick; req_valid = 4'hF;
    @(negedge clk);
    chk("bp_eval_ready", 32'(req_ready), 0);
    tick;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_rv", 32'(resp_valid), 1);
      chk("bp_resp_a", 32'(resp_a), 32'h36);
      chk("bp_resp_id", 32'(resp_id), 1);
      chk("bp_no_grant", 32'(req_ready), 0);
      if (i < 5) tick;
    end
    resp_ready = 1'b1;
    tick; resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_resume_grant", 32'(req_ready), 32'b0100);
    chk("bp_rv_clear", 32'(resp_valid), 0);

    // Reset during EVAL
    do_reset;
    req_valid = 4'b0001; req_z = 32'h00000044;
    @(negedge clk);
    chk("re_grant", 32'(req_ready), 1);
    tick; rst = 1'b1;
    @(negedge clk);
    chk("re_rst_no_ready", 32'(req_ready), 0);
    tick; rst = 1'b0; req_z = 32'h00000066;
    @(negedge clk);
    chk("re_rv_dropped", 32'(resp_valid), 0);
    chk("re_regrant", 32'(req_ready), 1);
    tick; req_valid = '0;
    @(negedge clk);
    chk("re_actz_new", 32'(act_z), 32'h66);
    tick;
    @(negedge clk);
    chk("re_rv", 32'(resp_valid), 1);
    chk("re_resp_a", 32'(resp_a), 32'h3C);
    resp_ready = 1'b1;
    tick; resp_ready = 1'b0;

    // Reset after traffic left registers non-zero
    req_valid = 4'hF; rst = 1'b1;
    tick;
    @(negedge clk);
    chk("rst2_req_ready", 32'(req_ready), 0);
    chk("rst2_act_z", 32'(act_z), 0);
    chk("rst2_resp_a", 32'(resp_a), 0);
    chk("rst2_rv", 32'(resp_valid), 0);
    tick; rst = 1'b0; req_valid = '0;

    // Randomized traffic vs. model
    m_ptr = 0; m_inflight = 0; m_eval = 0; m_rv = 0; m_z = '0; m_id = 0; m_a = '0;
    for (int c = 0; c < 2000; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      req_valid  = N'($urandom);
      req_z      = $urandom;
      resp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      g = -1;
      if (!rst && !m_inflight) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
      chk("rnd_req_ready", 32'(req_ready), (g >= 0) ? (32'(1) << g) : 0);
      chk("rnd_resp_valid", 32'(resp_valid), 32'(m_rv));
      chk("rnd_act_z", 32'(act_z), 32'(m_z));
      if (m_rv) begin
        chk("rnd_resp_a", 32'(resp_a), 32'(m_a));
        chk("rnd_resp_id", 32'(resp_id), 32'(m_id));
      end
      if (rst) begin
        m_ptr = 0; m_inflight = 0; m_eval = 0; m_rv = 0; m_z = '0; m_id = 0; m_a = '0;
      end else if (g >= 0) begin
        m_inflight = 1; m_eval = 1; m_z = req_z[8*g +: 8]; m_id = g; m_ptr = (g + 1) % N;
      end else if (m_eval) begin
        m_eval = 0; m_a = tanh_fn(m_z); m_rv = 1;
      end else if (m_rv && resp_ready) begin
        m_rv = 0; m_inflight = 0;
      end
      tick;
    end

`ifdef TANH_ARB_BUSY_COUNT_EN
    do_reset;
    @(negedge clk);
    chk("busy_reset", 32'(busy_cycles), 0);
    tick;
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = '{4'b0001, 8'(i + 1), 0, tanh_fn(8'(i + 1))};
      run_txn(v);
    end
    @(negedge clk);
    chk("busy_20", 32'(busy_cycles), 20);
    tick;
    req_valid = 4'b0001; resp_ready = 1'b0;
    for (int i = 0; i < 70000; i++) tick;
    @(negedge clk);
    chk("busy_sat", 32'(busy_cycles), 32'hFFFF);
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tanh_activation_arbiter.md
TANH_ACTIVATION_ARBITER -- requirements
Module: tanh_activation_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter ID_W, default 2: width of the requester index, equal to ceil(log2(NUM_REQ)).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ: per-requester request strobe.
REQ-006 SHALL have port req_z, input, 8*NUM_REQ: per-requester signed 8-bit pre-activation; slice i is bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, NUM_REQ: one-hot accept pulse to the granted requester.
REQ-008 SHALL have port act_z, output, 8: signed operand to the shared tanh LUT+interpolator unit.
REQ-009 SHALL have port act_a, input, 8: signed combinational result from the tanh unit for act_z.
REQ-010 SHALL have port resp_valid, output, 1: result available.
REQ-011 SHALL have port resp_a, output, 8: signed tanh result.
REQ-012 SHALL have port resp_id, output, ID_W: index of the requester that owns resp_a.
REQ-013 SHALL have port resp_ready, input, 1: consumer accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, EVAL and HOLD.
REQ-015 IDLE: if any req_valid bit is 1, SHALL grant one requester round-robin, starting the search at rr_ptr.
REQ-016 On grant, SHALL pulse that requester's req_ready for exactly one cycle, register its req_z into z_reg, register the index into id_reg, and go to EVAL.
REQ-017 SHALL advance rr_ptr to (grantee+1) mod NUM_REQ on every grant; with no grant, rr_ptr SHALL hold.
REQ-018 act_z SHALL be driven only from z_reg, never combinationally from req_z.
REQ-019 EVAL lasts exactly one cycle: SHALL capture act_a into resp_a, set resp_valid=1, and go to HOLD.
REQ-020 HOLD: resp_a and resp_id SHALL be stable while resp_valid=1 and resp_ready=0.
REQ-021 HOLD with resp_ready=1: SHALL clear resp_valid and return to IDLE; no grant occurs in that same cycle.
REQ-022 Latency SHALL be 2 cycles from a grant to resp_valid, and at least 3 cycles between successive grants.
REQ-023 req_ready SHALL be 0 in EVAL and HOLD; req_valid changes in those states SHALL have no effect.
REQ-024 A requester deasserting req_valid before it is granted SHALL be skipped; no request is latched speculatively.
REQ-025 With all NUM_REQ requesters continuously valid, each SHALL be granted exactly once per NUM_REQ grants.
REQ-026 No arithmetic is performed on z or a; 8-bit values SHALL pass bit-exact.

Reset
REQ-027 rst=1 SHALL force on the next edge: state=IDLE, rr_ptr=0, z_reg=0, id_reg=0, resp_a=0, resp_valid=0, req_ready=0.
REQ-028 rst SHALL dominate all other inputs, including mid-EVAL or mid-HOLD; an in-flight result SHALL be dropped with no response.
REQ-029 The first grant after reset release SHALL go to the lowest-index valid requester.

Configuration
REQ-030 With macro TANH_ARB_BUSY_COUNT_EN defined, SHALL add output busy_cycles[15:0].
REQ-031 busy_cycles SHALL count cycles with state != IDLE, saturate at 16'hFFFF, and clear on rst.
REQ-032 With TANH_ARB_BUSY_COUNT_EN undefined, port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Single request, no contention: rst, then req_valid=4'b0100 with req_z[23:16]=8'h30, act_a model returns 8'h2E for 8'h30 -> req_ready=4'b0100 one cycle; act_z=8'h30 in EVAL; resp_valid two cycles after the grant; resp_a=8'h2E; resp_id=2.
REQ-034 All four requesters held valid, resp_ready=1 -> grant order 0,1,2,3,0; grants spaced 3 cycles apart.
REQ-035 Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_a/resp_id unchanged; no req_ready pulse; grant resumes 1 cycle after the resp_ready handshake.
REQ-036 rst asserted in EVAL with req_valid=4'b0001 still high -> resp_valid stays 0; next grant goes to requester 0 with the new z.
REQ-037 Negative boundary: z=8'h80 and z=8'h7F -> resp_a equals the model's act_a, bit-exact, for both.
REQ-038 With TANH_ARB_BUSY_COUNT_EN: 10 back-to-back transactions with immediate resp_ready -> busy_cycles=20; forced 70000 busy cycles -> busy_cycles=16'hFFFF.
